// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi4_pkg
// Burst/response encodings and FSM state type shared by the AXI4 SRAM slave.
// Rev     : 1.0
// ============================================================================
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_R_WAIT = 3'd1,
        ST_R_DATA = 3'd2,
        ST_W_DATA = 3'd3,
        ST_W_RESP = 3'd4
    } state_t;

    // WRAP bursts advance like INCR; only FIXED holds the address.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bytewrite.sv
`default_nettype none
// ============================================================================
// Module : sram_bytewrite
// DEPTH_WORDS x 32 array, one registered read port, one byte-enabled write port.
// Rev    : 1.0
// ============================================================================
module sram_bytewrite #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module : axi4_sram_slave
// AXI4 subordinate serving one transaction at a time from an internal SRAM.
// Rev    : 1.0
// ============================================================================
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h8000_0000,
    parameter int          DEPTH_WORDS  = 4096,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [3:0]  rid,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          c_idx_w = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_limit = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_lat   = 4'(READ_LATENCY);

    function automatic logic beat_ok(input logic [31:0] addr, input logic [2:0] size);
        return ({1'b0, addr} >= {1'b0, ADDR_BASE}) && ({1'b0, addr} < c_limit) && (size <= 3'd2);
    endfunction

    function automatic logic [c_idx_w-1:0] word_idx(input logic [31:0] addr);
        return c_idx_w'((addr - ADDR_BASE) >> 2);
    endfunction

    state_t      r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_beat;
    logic [3:0]  r_lat;
    logic        r_last_read;
    logic        r_werr;

    logic        w_pick_w, w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;
    logic [31:0] w_r_next;
    logic        w_werr_next;
    logic        w_ld, w_ld_last, w_ld_ok;
    logic [31:0] w_ld_addr;
    logic [2:0]  w_ld_size;
    logic [31:0] w_sram_q;
    logic [3:0]  w_wr_be;

    assign w_pick_w = awvalid & (~arvalid | r_last_read);
    assign awready  = (r_state == ST_IDLE) & w_pick_w;
    assign arready  = (r_state == ST_IDLE) & arvalid & ~w_pick_w;
    assign rvalid   = (r_state == ST_R_DATA);
    assign wready   = (r_state == ST_W_DATA);
    assign bvalid   = (r_state == ST_W_RESP);

    assign w_ar_hs  = arvalid & arready;
    assign w_aw_hs  = awvalid & awready;
    assign w_r_hs   = rvalid & rready;
    assign w_w_hs   = wvalid & wready;
    assign w_r_next = next_addr(r_addr, r_size, r_burst);

    // Pick the address whose word is loaded into the read register this cycle.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_addr = r_addr;
        w_ld_size = r_size;
        w_ld_last = (r_beat == r_len);
        if (w_ar_hs && c_lat == 4'd0) begin
            w_ld      = 1'b1;
            w_ld_addr = araddr;
            w_ld_size = arsize;
            w_ld_last = (arlen == 8'd0);
        end else if (r_state == ST_R_WAIT && r_lat == 4'd1) begin
            w_ld      = 1'b1;
        end else if (w_r_hs && !rlast && c_lat == 4'd0) begin
            w_ld      = 1'b1;
            w_ld_addr = w_r_next;
            w_ld_last = (r_beat + 8'd1 == r_len);
        end
    end

    assign w_ld_ok     = beat_ok(w_ld_addr, w_ld_size);
    assign w_wr_be     = (w_w_hs && beat_ok(r_addr, r_size)) ? wstrb : 4'b0000;
    assign w_werr_next = r_werr | ~beat_ok(r_addr, r_size) | (wlast != (r_beat == r_len));
    assign rdata       = (rresp == RESP_SLVERR) ? 32'd0 : w_sram_q;

    sram_bytewrite #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_sram (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (w_ld & w_ld_ok),
        .rd_addr (word_idx(w_ld_addr)),
        .rd_data (w_sram_q),
        .wr_be   (w_wr_be),
        .wr_addr (word_idx(r_addr)),
        .wr_data (wdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_lat       <= '0;
            r_last_read <= 1'b0;
            r_werr      <= 1'b0;
            rid         <= '0;
            rresp       <= RESP_OKAY;
            rlast       <= 1'b0;
            bid         <= '0;
            bresp       <= RESP_OKAY;
        end else begin
            if (w_ld) begin
                rresp <= w_ld_ok ? RESP_OKAY : RESP_SLVERR;
                rlast <= w_ld_last;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_addr      <= awaddr;
                        r_len       <= awlen;
                        r_size      <= awsize;
                        r_burst     <= awburst;
                        bid         <= awid;
                        r_beat      <= '0;
                        r_werr      <= 1'b0;
                        r_last_read <= 1'b0;
                        r_state     <= ST_W_DATA;
                    end else if (w_ar_hs) begin
                        r_addr      <= araddr;
                        r_len       <= arlen;
                        r_size      <= arsize;
                        r_burst     <= arburst;
                        rid         <= arid;
                        r_beat      <= '0;
                        r_lat       <= c_lat;
                        r_last_read <= 1'b1;
                        r_state     <= (c_lat == 4'd0) ? ST_R_DATA : ST_R_WAIT;
                    end
                end
                ST_R_WAIT: begin
                    if (r_lat == 4'd1) begin
                        r_state <= ST_R_DATA;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                ST_R_DATA: begin
                    if (w_r_hs) begin
                        if (rlast) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= w_r_next;
                            r_lat   <= c_lat;
                            r_state <= (c_lat == 4'd0) ? ST_R_DATA : ST_R_WAIT;
                        end
                    end
                end
                ST_W_DATA: begin
                    if (w_w_hs) begin
                        r_werr <= w_werr_next;
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_r_next;
                        if (r_beat == r_len) begin
                            bresp   <= w_werr_next ? RESP_SLVERR : RESP_OKAY;
                            r_state <= ST_W_RESP;
                        end
                    end
                end
                ST_W_RESP: begin
                    if (bready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_axi4_sram_slave
// Directed bench for axi4_sram_slave with a byte-level memory model and R scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_axi4_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clock, reset;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arid, awid, wstrb, rid, bid;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi4_sram_slave #(
        .ADDR_BASE    (BASE),
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clock (clock), .reset (reset),
        .araddr (araddr), .arid (arid), .arlen (arlen), .arsize (arsize), .arburst (arburst),
        .arvalid (arvalid), .arready (arready),
        .rdata (rdata), .rid (rid), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready),
        .awaddr (awaddr), .awid (awid), .awlen (awlen), .awsize (awsize), .awburst (awburst),
        .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
        .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mbytes [logic [31:0]];
    beat_t       exp_q[$];
    beat_t       rx_q[$];
    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    int          ar_wait;
    logic        first_aw, first_ar;
    logic [3:0]  last_bid;
    logic [1:0]  last_bresp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic expire(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic bit in_range(input logic [31:0] a, input logic [2:0] size);
        logic [63:0] ua = {32'd0, a};
        logic [63:0] lo = {32'd0, BASE};
        return (ua >= lo) && (ua < lo + 64'(4 * DEPTH)) && (size <= 3'd2);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst, input int b);
        return (burst == 2'b00) ? a : a + (32'(b) << size);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w = {a[31:2], 2'b00};
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (mbytes.exists(w + 32'(i))) r[8*i +: 8] = mbytes[w + 32'(i)];
        return r;
    endfunction

    // Scoreboard: every cycle R is valid it must match the head of the expected stream.
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clock) begin
        beat_t r;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            check("ar_aw_exclusive", 32'(arready & awready), 32'd0);
            check("arready_busy", 32'(arready & (rvalid | wready | bvalid)), 32'd0);
            if (prev_stall) begin
                check("r_stall_valid", 32'(rvalid), 32'd1);
                check("r_stall_data", rdata, prev_data);
                check("r_stall_last", 32'(rlast), 32'(prev_last));
            end
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    check("r_unexpected_beat", 32'(rvalid), 32'd0);
                end else begin
                    check("rdata", rdata, exp_q[0].data);
                    check("rid", 32'(rid), 32'(exp_q[0].id));
                    check("rresp", 32'(rresp), 32'(exp_q[0].resp));
                    check("rlast", 32'(rlast), 32'(exp_q[0].last));
                    if (rready) begin
                        r.data = rdata; r.id = rid; r.resp = rresp; r.last = rlast;
                        rx_q.push_back(r);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = rvalid & ~rready;
            prev_data  = rdata;
            prev_last  = rlast;
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit bad_wlast);
        logic [31:0] a;
        bit          acc, err;
        int          t;
        awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wdata = wd[0]; wstrb = ws[0]; wlast = (len == 8'd0) ^ bad_wlast; wvalid = 1'b1;
        t = 0; acc = 1'b0;
        while (!acc && t < 50) begin
            @(negedge clock);
            if (t == 0) begin
                first_aw = awready; first_ar = arready;
                check("wready_early", 32'(wready), 32'd0);
            end
            acc = awready; t++;
            @(posedge clock); #1;
        end
        awvalid = 1'b0;
        if (!acc) begin expire("aw_accept"); wvalid = 1'b0; return; end
        err = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            a = beat_addr(addr, size, burst, b);
            wdata = wd[b]; wstrb = ws[b];
            wlast = (b == int'(len)) ^ (bad_wlast && b == 0);
            t = 0; acc = 1'b0;
            while (!acc && t < 50) begin
                @(negedge clock); acc = wready; t++;
                @(posedge clock); #1;
            end
            if (!acc) begin expire("w_accept"); wvalid = 1'b0; return; end
            if (in_range(a, size)) begin
                for (int l = 0; l < 4; l++)
                    if (ws[b][l]) mbytes[{a[31:2], 2'b00} + 32'(l)] = wd[b][8*l +: 8];
            end else begin
                err = 1'b1;
            end
            if (wlast != (b == int'(len))) err = 1'b1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin @(posedge clock); #1; t++; end
        if (!bvalid) begin expire("b_valid"); return; end
        check("bid", 32'(bid), 32'(id));
        check("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
        last_bid = bid; last_bresp = bresp;
        @(posedge clock); #1;
        check("bvalid_hold", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_cyc, input int rst_beat);
        beat_t       e;
        logic [31:0] a;
        bit          acc;
        int          t, cyc;
        for (int b = 0; b <= int'(len); b++) begin
            a = beat_addr(addr, size, burst, b);
            e.id = id; e.last = (b == int'(len));
            if (in_range(a, size)) begin e.data = model_word(a); e.resp = 2'b00; end
            else begin e.data = 32'd0; e.resp = 2'b10; end
            exp_q.push_back(e);
        end
        rx_q.delete();
        araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b0;
        t = 0; acc = 1'b0;
        while (!acc && t < 50) begin
            @(negedge clock); acc = arready; t++;
            @(posedge clock); #1;
        end
        arvalid = 1'b0; ar_wait = t;
        if (!acc) begin expire("ar_accept"); exp_q.delete(); return; end
        cyc = 0;
        while (!rvalid && cyc < 40) begin @(posedge clock); #1; cyc++; end
        check("r_latency", 32'(cyc), 32'(LAT));
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!rvalid && t < 40) begin @(posedge clock); #1; t++; end
            if (!rvalid) begin expire("r_beat"); exp_q.delete(); return; end
            if (b == rst_beat) begin
                #2 reset = 1'b0;
                #1;
                check("rst_rvalid", 32'(rvalid), 32'd0);
                check("rst_rlast", 32'(rlast), 32'd0);
                check("rst_rdata", rdata, 32'd0);
                exp_q.delete();
                repeat (2) @(posedge clock);
                #3 reset = 1'b1;
                @(posedge clock); #1;
                return;
            end
            if (b == stall_beat) repeat (stall_cyc) begin @(posedge clock); #1; end
            rready = 1'b1;
            @(posedge clock); #1;
            rready = 1'b0;
        end
        check("r_beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; rready = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        #3;
        check("rst_rvalid0", 32'(rvalid), 32'd0);
        check("rst_wready0", 32'(wready), 32'd0);
        check("rst_bvalid0", 32'(bvalid), 32'd0);
        check("rst_rlast0", 32'(rlast), 32'd0);
        check("rst_rdata0", rdata, 32'd0);
        check("rst_rid0", 32'(rid), 32'd0);
        check("rst_bresp0", 32'({bid, bresp, rresp}), 32'd0);
        check("rst_ready0", 32'({arready, awready}), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        // Full-word write then read back
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(32'h8000_0010, 4'd3, 8'd0, 3'd2, 2'b01, 1'b0);
        check("t1_bresp", 32'(last_bresp), 32'd0);
        check("t1_bid", 32'(last_bid), 32'd3);
        do_read(32'h8000_0010, 4'd5, 8'd0, 3'd2, 2'b01, -1, 0, -1);
        check("t1_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) begin
            check("t1_rdata", rx_q[0].data, 32'hDEAD_BEEF);
            check("t1_rid", 32'(rx_q[0].id), 32'd5);
            check("t1_rresp_rlast", 32'({rx_q[0].resp, rx_q[0].last}), 32'b001);
        end

        // Byte store into lane 1
        wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
        do_write(32'h8000_0011, 4'd1, 8'd0, 3'd0, 2'b01, 1'b0);
        do_read(32'h8000_0010, 4'd2, 8'd0, 3'd2, 2'b01, -1, 0, -1);
        if (rx_q.size() > 0) check("t2_rdata", rx_q[0].data, 32'hDEAD_ABEF);
        else expire("t2_rx");

        // Preload by INCR write burst, then INCR read burst with a stall on beat 2
        wd = '{32'h11, 32'h22, 32'h33, 32'h44};
        ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h8000_0000, 4'd4, 8'd3, 3'd2, 2'b01, 1'b0);
        do_read(32'h8000_0000, 4'd6, 8'd3, 3'd2, 2'b01, 1, 3, -1);
        check("t3_rx_count", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            check("t3_beat0", rx_q[0].data, 32'h11);
            check("t3_beat1", rx_q[1].data, 32'h22);
            check("t3_beat2", rx_q[2].data, 32'h33);
            check("t3_beat3", rx_q[3].data, 32'h44);
            check("t3_rlast", 32'({rx_q[0].last, rx_q[1].last, rx_q[2].last, rx_q[3].last}), 32'b0001);
        end

        // Simultaneous AR and AW after a read: write wins, read follows
        araddr = 32'h8000_0008; arid = 4'd7; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        do_write(32'h8000_0008, 4'd8, 8'd0, 3'd2, 2'b01, 1'b0);
        check("t4_awready_first", 32'(first_aw), 32'd1);
        check("t4_arready_first", 32'(first_ar), 32'd0);
        do_read(32'h8000_0008, 4'd7, 8'd0, 3'd2, 2'b01, -1, 0, -1);
        check("t4_ar_wait", 32'(ar_wait), 32'd1);
        if (rx_q.size() > 0) check("t4_rdata", rx_q[0].data, 32'hCAFE_F00D);
        else expire("t4_rx");

        // Error responses: out of range below/above, oversize, wlast mismatch
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(32'h0000_0000, 4'd9, 8'd0, 3'd2, 2'b01, 1'b0);
        check("t5_bresp", 32'(last_bresp), 32'd2);
        do_read(32'h0000_0000, 4'd10, 8'd0, 3'd2, 2'b01, -1, 0, -1);
        if (rx_q.size() > 0) begin
            check("t5_rresp", 32'(rx_q[0].resp), 32'd2);
            check("t5_rdata", rx_q[0].data, 32'd0);
        end else expire("t5_rx");
        do_read(32'h8000_0000, 4'd11, 8'd0, 3'd2, 2'b01, -1, 0, -1);
        if (rx_q.size() > 0) check("t5_unchanged", rx_q[0].data, 32'h11);
        else expire("t5_rx2");
        wd[0] = 32'h0BAD_F00D;
        do_write(32'h8000_4000, 4'd12, 8'd0, 3'd2, 2'b01, 1'b0);
        check("t5_top_bresp", 32'(last_bresp), 32'd2);
        do_write(32'h8000_3FFC, 4'd13, 8'd0, 3'd2, 2'b01, 1'b0);
        check("t5_last_word_bresp", 32'(last_bresp), 32'd0);
        do_read(32'h8000_3FFC, 4'd13, 8'd0, 3'd2, 2'b01, -1, 0, -1);
        do_read(32'h8000_0000, 4'd14, 8'd0, 3'd3, 2'b01, -1, 0, -1);
        wd[0] = 32'h5A5A_5A5A;
        do_write(32'h8000_0020, 4'd15, 8'd0, 3'd2, 2'b01, 1'b1);
        check("t5_wlast_bresp", 32'(last_bresp), 32'd2);
        do_read(32'h8000_0020, 4'd1, 8'd0, 3'd2, 2'b00, -1, 0, -1);

        // Reset during beat 2 of a 4-beat read, then a fresh read
        do_read(32'h8000_0000, 4'd2, 8'd3, 3'd2, 2'b01, -1, 0, 1);
        do_read(32'h8000_0000, 4'd3, 8'd3, 3'd2, 2'b01, -1, 0, -1);
        check("t6_ar_wait", 32'(ar_wait), 32'd1);
        if (rx_q.size() == 4) begin
            check("t6_beat0", rx_q[0].data, 32'h11);
            check("t6_beat3", rx_q[3].data, 32'h44);
        end else expire("t6_rx");

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
